// File: rtl/ara_ring_router_mh_pkg.sv
// ara_ring_router_mh_pkg: shared ring router types, direction constants and hop-width helper
//   elen_t / ring_flit_t / ring_conf_t give the default-width (64-bit, 4-cluster) views of a flit
//   and of the configuration; the router re-derives them from its own parameters.
package ara_ring_router_mh_pkg;
  localparam int unsigned ElenWidth = 64;
  localparam int unsigned DefaultClusters = 4;
  localparam logic RingDirLeft = 1'b0;
  localparam logic RingDirRight = 1'b1;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [ElenWidth-1:0] elen_t;
  typedef struct packed {
    logic [idx_width(DefaultClusters)-1:0] hops;
    elen_t data;
  } ring_flit_t;
  typedef struct packed {
    logic dir;
    logic bypass;
    logic [idx_width(DefaultClusters)-1:0] hops;
  } ring_conf_t;
endpackage

// File: rtl/ara_ring_router_mh_fifo.sv
// ara_ring_fifo: non-fall-through FIFO with synchronous active-high reset
//   clk_i/rst_i          clock, synchronous active-high reset
//   push_i/data_i        write request (ignored when full) and write data
//   pop_i/data_o         read request (ignored when empty) and head entry
//   full_o/empty_o       occupancy flags
//   usage_o              number of stored entries
module ara_ring_fifo #(
  parameter int unsigned Depth = 2,
  parameter type T = logic,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output T                data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] usage_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  T mem [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q;
  logic push, pop;
  assign full_o = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign usage_o = cnt_q;
  assign push = push_i && !full_o;
  assign pop = pop_i && !empty_o;
  assign data_o = mem[rd_q];
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
    end
  end
endmodule

// File: rtl/ara_ring_router_mh.sv
// ara_ring_router_mh: multi-hop ring router between an Ara SLDU and its left/right ring neighbours
//   clk_i/rst_i                          clock, synchronous active-high reset
//   conf_valid_i/dir/bypass/hops         configuration strobe and fields (loaded only when idle)
//   busy_o/conf_err_o                    occupancy flag, rejected-configuration pulse
//   sldu_i/_valid_i/_ready_o             local injection
//   sldu_o/_valid_o/_ready_i             local ejection
//   ring_{right,left}_i/_valid_i/_ready_o  ring ingress ({hops, data}), buffered in FIFOs
//   ring_{right,left}_o/_valid_o/_ready_i  ring egress, 1-entry output register
//   perf_{fwd,inj,ej,stall}_o            32-bit counters, present only with ARA_RING_ROUTER_PERF_EN
module ara_ring_router_mh
  import ara_ring_router_mh_pkg::*;
#(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NrClusters = 4,
  parameter int unsigned FifoDepth  = 2,
  parameter int unsigned HopWidth   = idx_width(NrClusters)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          conf_valid_i,
  input  logic                          conf_dir_i,
  input  logic                          conf_bypass_i,
  input  logic [HopWidth-1:0]           conf_hops_i,
  output logic                          busy_o,
  output logic                          conf_err_o,
  input  logic [DataWidth-1:0]          sldu_i,
  input  logic                          sldu_valid_i,
  output logic                          sldu_ready_o,
  output logic [DataWidth-1:0]          sldu_o,
  output logic                          sldu_valid_o,
  input  logic                          sldu_ready_i,
  input  logic [HopWidth+DataWidth-1:0] ring_right_i,
  input  logic                          ring_right_valid_i,
  output logic                          ring_right_ready_o,
  input  logic [HopWidth+DataWidth-1:0] ring_left_i,
  input  logic                          ring_left_valid_i,
  output logic                          ring_left_ready_o,
  output logic [HopWidth+DataWidth-1:0] ring_right_o,
  output logic                          ring_right_valid_o,
  input  logic                          ring_right_ready_i,
  output logic [HopWidth+DataWidth-1:0] ring_left_o,
  output logic                          ring_left_valid_o,
  input  logic                          ring_left_ready_i,
  output logic [31:0]                   perf_fwd_o,
  output logic [31:0]                   perf_inj_o,
  output logic [31:0]                   perf_ej_o,
  output logic [31:0]                   perf_stall_o
);
  typedef struct packed {
    logic [HopWidth-1:0]  hops;
    logic [DataWidth-1:0] data;
  } flit_t;
  typedef struct packed {
    logic                dir;
    logic                bypass;
    logic [HopWidth-1:0] hops;
  } conf_t;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  conf_t conf_q;
  flit_t head_r, head_l, head, out_q;
  logic full_r, full_l, empty_r, empty_l;
  logic [CntW-1:0] usage_r, usage_l;
  logic out_v, byp_v, rr_q;
  logic [DataWidth-1:0] byp_q;
  logic rx_right, head_v, fwd_req, ej_v, ej_fire, out_ready, out_space;
  logic fwd_gnt, inj_gnt, pop_r, pop_l;
  // Slidedown sends left and therefore listens to the right neighbour.
  assign rx_right = conf_q.dir == RingDirLeft;
  assign head = rx_right ? head_r : head_l;
  assign head_v = !conf_q.bypass && (rx_right ? !empty_r : !empty_l);
  assign fwd_req = head_v && head.hops != '0;
  assign ej_v = head_v && head.hops == '0;
  assign ej_fire = ej_v && sldu_ready_i;
  assign out_ready = rx_right ? ring_left_ready_i : ring_right_ready_i;
  assign out_space = !out_v || out_ready;
  // rr_q=0 favours the forwarded flit; ready is derived from state only, never from sldu_valid_i.
  assign sldu_ready_o = !rst_i && (conf_q.bypass ? (!byp_v || sldu_ready_i)
                                                 : out_space && (!fwd_req || rr_q));
  assign inj_gnt = !conf_q.bypass && sldu_valid_i && sldu_ready_o;
  assign fwd_gnt = fwd_req && out_space && (!sldu_valid_i || !rr_q);
  assign pop_r = rx_right && (fwd_gnt || ej_fire);
  assign pop_l = !rx_right && (fwd_gnt || ej_fire);
  assign ring_right_ready_o = !rst_i && !conf_q.bypass && rx_right && !full_r;
  assign ring_left_ready_o = !rst_i && !conf_q.bypass && !rx_right && !full_l;
  assign ring_right_o = out_q;
  assign ring_left_o = out_q;
  assign ring_right_valid_o = !rst_i && out_v && !rx_right;
  assign ring_left_valid_o = !rst_i && out_v && rx_right;
  assign sldu_o = conf_q.bypass ? byp_q : head.data;
  assign sldu_valid_o = !rst_i && (conf_q.bypass ? byp_v : ej_v);
  assign busy_o = out_v || byp_v || usage_r != '0 || usage_l != '0;
  ara_ring_fifo #(.Depth(FifoDepth), .T(flit_t)) i_fifo_right (
    .clk_i,
    .rst_i,
    .push_i  (ring_right_valid_i && ring_right_ready_o),
    .data_i  (ring_right_i),
    .pop_i   (pop_r),
    .data_o  (head_r),
    .full_o  (full_r),
    .empty_o (empty_r),
    .usage_o (usage_r)
  );
  ara_ring_fifo #(.Depth(FifoDepth), .T(flit_t)) i_fifo_left (
    .clk_i,
    .rst_i,
    .push_i  (ring_left_valid_i && ring_left_ready_o),
    .data_i  (ring_left_i),
    .pop_i   (pop_l),
    .data_o  (head_l),
    .full_o  (full_l),
    .empty_o (empty_l),
    .usage_o (usage_l)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conf_q <= '{dir: RingDirLeft, bypass: 1'b1, hops: HopWidth'(1)};
      conf_err_o <= 1'b0;
      out_v <= 1'b0;
      out_q <= '0;
      byp_v <= 1'b0;
      byp_q <= '0;
      rr_q <= 1'b0;
    end else begin
      conf_err_o <= conf_valid_i && busy_o;
      if (conf_valid_i && !busy_o)
        conf_q <= '{dir: conf_dir_i, bypass: conf_bypass_i || conf_hops_i == '0, hops: conf_hops_i};
      if (out_space) begin
        out_v <= fwd_gnt || inj_gnt;
        if (fwd_gnt) out_q <= '{hops: head.hops - 1'b1, data: head.data};
        else if (inj_gnt) out_q <= '{hops: conf_q.hops - 1'b1, data: sldu_i};
      end
      if (!byp_v || sldu_ready_i) begin
        byp_v <= conf_q.bypass && sldu_valid_i;
        if (sldu_valid_i) byp_q <= sldu_i;
      end
      if (fwd_req && sldu_valid_i && out_space) rr_q <= !rr_q;
    end
  end
`ifdef ARA_RING_ROUTER_PERF_EN
  logic [31:0] fwd_cnt, inj_cnt, ej_cnt, stall_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_cnt <= '0;
      inj_cnt <= '0;
      ej_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fwd_cnt <= fwd_cnt + 32'(fwd_gnt);
      inj_cnt <= inj_cnt + 32'(sldu_valid_i && sldu_ready_o);
      ej_cnt <= ej_cnt + 32'(sldu_valid_o && sldu_ready_i);
      stall_cnt <= stall_cnt + 32'(out_v && !out_ready);
    end
  end
  assign perf_fwd_o = fwd_cnt;
  assign perf_inj_o = inj_cnt;
  assign perf_ej_o = ej_cnt;
  assign perf_stall_o = stall_cnt;
`else
  assign perf_fwd_o = '0;
  assign perf_inj_o = '0;
  assign perf_ej_o = '0;
  assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_ara_ring_router_mh.sv
// tb_ara_ring_router_mh: directed self-checking bench for the multi-hop ring router
module tb_ara_ring_router_mh;
  logic clk = 1'b0, rst = 1'b1;
  logic conf_valid = 1'b0, conf_dir = 1'b0, conf_bypass = 1'b0;
  logic [1:0] conf_hops = 2'd0;
  logic busy_o, conf_err_o;
  logic [63:0] sldu_i = '0, sldu_o;
  logic sldu_valid = 1'b0, sldu_ready_o, sldu_valid_o, sldu_ready = 1'b1;
  logic [65:0] ring_right_i = '0, ring_left_i = '0, ring_right_o, ring_left_o;
  logic ring_right_valid = 1'b0, ring_left_valid = 1'b0;
  logic ring_right_ready_o, ring_left_ready_o;
  logic ring_right_valid_o, ring_left_valid_o;
  logic ring_right_ready = 1'b1, ring_left_ready = 1'b1;
  logic [31:0] perf_fwd_o, perf_inj_o, perf_ej_o, perf_stall_o;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  ara_ring_router_mh #(.DataWidth(64), .NrClusters(4), .FifoDepth(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .conf_valid_i(conf_valid), .conf_dir_i(conf_dir), .conf_bypass_i(conf_bypass), .conf_hops_i(conf_hops),
    .busy_o(busy_o), .conf_err_o(conf_err_o),
    .sldu_i(sldu_i), .sldu_valid_i(sldu_valid), .sldu_ready_o(sldu_ready_o),
    .sldu_o(sldu_o), .sldu_valid_o(sldu_valid_o), .sldu_ready_i(sldu_ready),
    .ring_right_i(ring_right_i), .ring_right_valid_i(ring_right_valid), .ring_right_ready_o(ring_right_ready_o),
    .ring_left_i(ring_left_i), .ring_left_valid_i(ring_left_valid), .ring_left_ready_o(ring_left_ready_o),
    .ring_right_o(ring_right_o), .ring_right_valid_o(ring_right_valid_o), .ring_right_ready_i(ring_right_ready),
    .ring_left_o(ring_left_o), .ring_left_valid_o(ring_left_valid_o), .ring_left_ready_i(ring_left_ready),
    .perf_fwd_o(perf_fwd_o), .perf_inj_o(perf_inj_o), .perf_ej_o(perf_ej_o), .perf_stall_o(perf_stall_o)
  );

  task automatic cfg(input logic dir, input logic byp, input logic [1:0] hops);
    conf_dir = dir; conf_bypass = byp; conf_hops = hops; conf_valid = 1'b1;
    @(negedge clk);
    conf_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if ({sldu_ready_o, sldu_valid_o, ring_right_ready_o, ring_left_ready_o, ring_right_valid_o, ring_left_valid_o} !== 6'b0)
      $display("FAIL reset_hs: got %b expected 000000", {sldu_ready_o, sldu_valid_o, ring_right_ready_o, ring_left_ready_o, ring_right_valid_o, ring_left_valid_o}); else passed++;
    total++; if ({busy_o, conf_err_o} !== 2'b00) $display("FAIL reset_busy_err: got %b expected 00", {busy_o, conf_err_o}); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({sldu_ready_o, ring_right_ready_o, ring_left_ready_o} !== 3'b100)
      $display("FAIL reset_bypass_default: got %b expected 100", {sldu_ready_o, ring_right_ready_o, ring_left_ready_o}); else passed++;
    total++; if ({perf_fwd_o, perf_inj_o, perf_ej_o, perf_stall_o} !== 128'd0) $display("FAIL reset_perf: got %h expected 0", {perf_fwd_o, perf_inj_o, perf_ej_o, perf_stall_o}); else passed++;
  endtask

  task automatic test_single_hop();
    cfg(1'b1, 1'b0, 2'd1);
    sldu_i = 64'hA5; sldu_valid = 1'b1;
    @(negedge clk);
    sldu_valid = 1'b0;
    total++; if ({ring_right_valid_o, ring_right_o} !== {1'b1, 2'd0, 64'hA5}) $display("FAIL single_inj: got %h expected %h", {ring_right_valid_o, ring_right_o}, {1'b1, 2'd0, 64'hA5}); else passed++;
    total++; if (ring_left_valid_o !== 1'b0) $display("FAIL single_inactive_out: got %b expected 0", ring_left_valid_o); else passed++;
    ring_left_i = {2'd0, 64'h5A}; ring_left_valid = 1'b1;
    total++; if ({ring_left_ready_o, ring_right_ready_o} !== 2'b10) $display("FAIL single_in_ready: got %b expected 10", {ring_left_ready_o, ring_right_ready_o}); else passed++;
    @(negedge clk);
    ring_left_valid = 1'b0;
    total++; if ({sldu_valid_o, sldu_o} !== {1'b1, 64'h5A}) $display("FAIL single_eject: got %h expected %h", {sldu_valid_o, sldu_o}, {1'b1, 64'h5A}); else passed++;
    total++; if (ring_right_valid_o !== 1'b0) $display("FAIL single_out_drained: got %b expected 0", ring_right_valid_o); else passed++;
    @(negedge clk);
    total++; if ({sldu_valid_o, busy_o} !== 2'b00) $display("FAIL single_idle: got %b expected 00", {sldu_valid_o, busy_o}); else passed++;
  endtask

  task automatic test_multi_hop();
    cfg(1'b1, 1'b0, 2'd3);
    sldu_i = 64'h1234; sldu_valid = 1'b1;
    @(negedge clk);
    sldu_valid = 1'b0;
    total++; if ({ring_right_valid_o, ring_right_o} !== {1'b1, 2'd2, 64'h1234}) $display("FAIL multi_inj_hops2: got %h expected %h", {ring_right_valid_o, ring_right_o}, {1'b1, 2'd2, 64'h1234}); else passed++;
    for (int h = 2; h >= 1; h--) begin
      ring_left_i = {2'(h), 64'hBEEF00 + 64'(h)}; ring_left_valid = 1'b1;
      @(negedge clk);
      ring_left_valid = 1'b0;
      total++; if (sldu_valid_o !== 1'b0) $display("FAIL multi_no_eject_h%0d: got %b expected 0", h, sldu_valid_o); else passed++;
      @(negedge clk);
      total++; if ({ring_right_valid_o, ring_right_o} !== {1'b1, 2'(h - 1), 64'hBEEF00 + 64'(h)})
        $display("FAIL multi_fwd_h%0d: got %h expected %h", h, {ring_right_valid_o, ring_right_o}, {1'b1, 2'(h - 1), 64'hBEEF00 + 64'(h)}); else passed++;
    end
    ring_left_i = {2'd0, 64'hBEEF00}; ring_left_valid = 1'b1;
    @(negedge clk);
    ring_left_valid = 1'b0;
    total++; if ({sldu_valid_o, sldu_o, ring_right_valid_o} !== {1'b1, 64'hBEEF00, 1'b0}) $display("FAIL multi_eject: got %h expected %h", {sldu_valid_o, sldu_o, ring_right_valid_o}, {1'b1, 64'hBEEF00, 1'b0}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n_inj, n_fwd, order_err, alt_err;
    logic ia, fa, seen;
    logic [1:0] prev_h;
    n_inj = 0; n_fwd = 0; order_err = 0; alt_err = 0; seen = 1'b0; prev_h = 2'd0;
    cfg(1'b1, 1'b0, 2'd2);
    sldu_i = 64'h100; sldu_valid = 1'b1;
    ring_left_i = {2'd1, 64'h200}; ring_left_valid = 1'b1;
    repeat (20) begin
      ia = sldu_ready_o; fa = ring_left_ready_o;
      @(negedge clk);
      if (ia) sldu_i = sldu_i + 64'd1;
      if (fa) ring_left_i[63:0] = ring_left_i[63:0] + 64'd1;
      if (ring_right_valid_o) begin
        if (ring_right_o[65:64] == 2'd1) begin
          if (ring_right_o[63:0] !== 64'h100 + 64'(n_inj)) order_err++;
          n_inj++;
        end else begin
          if (ring_right_o[63:0] !== 64'h200 + 64'(n_fwd)) order_err++;
          n_fwd++;
        end
        if (seen && ring_right_o[65:64] == prev_h) alt_err++;
        prev_h = ring_right_o[65:64]; seen = 1'b1;
      end
    end
    sldu_valid = 1'b0; ring_left_valid = 1'b0;
    total++; if (n_inj !== 10) $display("FAIL contention_inj_count: got %0d expected 10", n_inj); else passed++;
    total++; if (n_fwd !== 10) $display("FAIL contention_fwd_count: got %0d expected 10", n_fwd); else passed++;
    total++; if (order_err !== 0) $display("FAIL contention_order: got %0d errors expected 0", order_err); else passed++;
    total++; if (alt_err !== 0) $display("FAIL contention_alternate: got %0d repeats expected 0", alt_err); else passed++;
    repeat (6) @(negedge clk);
    total++; if (busy_o !== 1'b0) $display("FAIL contention_drain: got %b expected 0", busy_o); else passed++;
  endtask

  task automatic test_backpressure();
    int acc, got, err;
    logic a;
    acc = 0; got = 0; err = 0;
    cfg(1'b1, 1'b0, 2'd2);
    ring_right_ready = 1'b0;
    ring_left_i = {2'd1, 64'h300}; ring_left_valid = 1'b1;
    repeat (6) begin
      a = ring_left_ready_o;
      @(negedge clk);
      if (a) begin acc++; ring_left_i[63:0] = ring_left_i[63:0] + 64'd1; end
    end
    ring_left_valid = 1'b0;
    total++; if (acc !== 3) $display("FAIL bp_accepts: got %0d expected 3", acc); else passed++;
    total++; if (ring_left_ready_o !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", ring_left_ready_o); else passed++;
    total++; if ({busy_o, ring_right_valid_o, ring_right_o} !== {2'b11, 2'd0, 64'h300}) $display("FAIL bp_held: got %h expected %h", {busy_o, ring_right_valid_o, ring_right_o}, {2'b11, 2'd0, 64'h300}); else passed++;
    ring_right_ready = 1'b1;
    repeat (6) begin
      if (ring_right_valid_o) begin
        if (ring_right_o !== {2'd0, 64'h300 + 64'(got)}) err++;
        got++;
      end
      @(negedge clk);
    end
    total++; if (got !== 3) $display("FAIL bp_release_count: got %0d expected 3", got); else passed++;
    total++; if (err !== 0) $display("FAIL bp_release_order: got %0d errors expected 0", err); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL bp_idle: got %b expected 0", busy_o); else passed++;
  endtask

  task automatic test_conf_busy();
    cfg(1'b1, 1'b0, 2'd1);
    ring_right_ready = 1'b0;
    sldu_i = 64'h77; sldu_valid = 1'b1;
    @(negedge clk);
    sldu_valid = 1'b0;
    total++; if (busy_o !== 1'b1) $display("FAIL cb_busy: got %b expected 1", busy_o); else passed++;
    conf_dir = 1'b0; conf_bypass = 1'b0; conf_hops = 2'd1; conf_valid = 1'b1;
    @(negedge clk);
    conf_valid = 1'b0;
    total++; if (conf_err_o !== 1'b1) $display("FAIL cb_err_pulse: got %b expected 1", conf_err_o); else passed++;
    total++; if ({ring_left_ready_o, ring_right_ready_o, ring_right_valid_o} !== 3'b101) $display("FAIL cb_old_dir: got %b expected 101", {ring_left_ready_o, ring_right_ready_o, ring_right_valid_o}); else passed++;
    @(negedge clk);
    total++; if (conf_err_o !== 1'b0) $display("FAIL cb_err_one_cycle: got %b expected 0", conf_err_o); else passed++;
    ring_right_ready = 1'b1;
    @(negedge clk);
    total++; if (busy_o !== 1'b0) $display("FAIL cb_drained: got %b expected 0", busy_o); else passed++;
    conf_valid = 1'b1;
    @(negedge clk);
    conf_valid = 1'b0;
    total++; if ({conf_err_o, ring_left_ready_o, ring_right_ready_o} !== 3'b001) $display("FAIL cb_accepted: got %b expected 001", {conf_err_o, ring_left_ready_o, ring_right_ready_o}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_hops0_perf();
`ifdef ARA_RING_ROUTER_PERF_EN
    logic [31:0] p0;
`endif
    cfg(1'b1, 1'b0, 2'd0);
`ifdef ARA_RING_ROUTER_PERF_EN
    p0 = perf_inj_o;
`endif
    sldu_i = 64'h11; sldu_valid = 1'b1;
    @(negedge clk);
    sldu_valid = 1'b0;
    total++; if ({sldu_valid_o, sldu_o} !== {1'b1, 64'h11}) $display("FAIL hops0_loop: got %h expected %h", {sldu_valid_o, sldu_o}, {1'b1, 64'h11}); else passed++;
    total++; if ({ring_right_valid_o, ring_left_valid_o, ring_right_ready_o, ring_left_ready_o} !== 4'b0)
      $display("FAIL hops0_ring_idle: got %b expected 0000", {ring_right_valid_o, ring_left_valid_o, ring_right_ready_o, ring_left_ready_o}); else passed++;
`ifdef ARA_RING_ROUTER_PERF_EN
    total++; if (perf_inj_o !== p0 + 32'd1) $display("FAIL perf_inj: got %0d expected %0d", perf_inj_o, p0 + 32'd1); else passed++;
`else
    total++; if ({perf_fwd_o, perf_inj_o, perf_ej_o, perf_stall_o} !== 128'd0) $display("FAIL perf_zero: got %h expected 0", {perf_fwd_o, perf_inj_o, perf_ej_o, perf_stall_o}); else passed++;
`endif
    @(negedge clk);
    total++; if (sldu_valid_o !== 1'b0) $display("FAIL hops0_drain: got %b expected 0", sldu_valid_o); else passed++;
  endtask

  task automatic test_reset_mid();
    cfg(1'b1, 1'b0, 2'd1);
    ring_right_ready = 1'b0;
    sldu_i = 64'h99; sldu_valid = 1'b1;
    ring_left_i = {2'd1, 64'h98}; ring_left_valid = 1'b1;
    @(negedge clk);
    sldu_valid = 1'b0; ring_left_valid = 1'b0;
    total++; if (busy_o !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy_o); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({ring_right_valid_o, sldu_valid_o, ring_left_ready_o, sldu_ready_o} !== 4'b0) $display("FAIL mid_rst_outputs: got %b expected 0000", {ring_right_valid_o, sldu_valid_o, ring_left_ready_o, sldu_ready_o}); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({busy_o, ring_right_valid_o, ring_left_ready_o} !== 3'b000) $display("FAIL mid_dropped: got %b expected 000", {busy_o, ring_right_valid_o, ring_left_ready_o}); else passed++;
    ring_right_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_hop();
    test_multi_hop();
    test_contention();
    test_backpressure();
    test_conf_busy();
    test_hops0_perf();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ara_ring_router_mh.md
# ara_ring_router_mh

Multi-hop, parametrised ring router that connects one Ara cluster's slide unit (SLDU) to its left and right neighbours on the inter-cluster ring. It extends single-hop forwarding in three ways: each flit carries a hop count so a slide can cross several clusters, the ring input ports are buffered FIFOs, and local injection and through-traffic are arbitrated round-robin. There is one instance per cluster macro, sitting between the `ara` SLDU ring ports and the macro's ring ports.

## Interface
- `DataWidth`, 64: SLDU payload width in bits (`$bits(elen_t)`).
- `NrClusters`, 4: number of clusters on the ring; must be at least 2.
- `FifoDepth`, 2: entries per ring ingress FIFO; must be at least 2.
- `HopWidth`, `cf_math_pkg::idx_width(NrClusters)`: width of the hop field. Derived; do not override.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous and active-high. The block has one clock; the reset is synchronous and active-high.
- `conf_valid_i` input 1: configuration strobe.
- `conf_dir_i` input 1: direction. 0 = slidedown (send left, receive from right). 1 = slideup (send right, receive from left).
- `conf_bypass_i` input 1: local loopback; ring ports unused.
- `conf_hops_i` input HopWidth: number of clusters a flit travels.
- `busy_o` output 1: any FIFO, output register or SLDU output is occupied.
- `conf_err_o` output 1: one-cycle pulse when a configuration is rejected.
- `sldu_i` / `sldu_valid_i` / `sldu_ready_o`: input DataWidth / input 1 / output 1. Local injection.
- `sldu_o` / `sldu_valid_o` / `sldu_ready_i`: output DataWidth / output 1 / input 1. Local ejection.
- `ring_right_i` / `ring_right_valid_i` / `ring_right_ready_o`: input HopWidth+DataWidth / input 1 / output 1.
- `ring_left_i` / `ring_left_valid_i` / `ring_left_ready_o`: same widths as the right input.
- `ring_right_o` / `ring_right_valid_o` / `ring_right_ready_i`: output HopWidth+DataWidth / output 1 / input 1.
- `ring_left_o` / `ring_left_valid_o` / `ring_left_ready_i`: same widths as the right output.
- `perf_fwd_o`, `perf_inj_o`, `perf_ej_o`, `perf_stall_o`: output 32 each. Performance counters (see Configuration).

## Operation
- **Flit format.** A flit is `{hops, data}`, with `hops` in the MSBs.
- **Configuration register.**
  - Loaded on `conf_valid_i` only when `busy_o`=0.
  - If `conf_valid_i` arrives while busy, the configuration is ignored and `conf_err_o` pulses in the next cycle.
  - `conf_hops_i`=0 is treated as bypass.
  - Reset value: dir=0, bypass=1, hops=1.
- **Bypass.**
  - `sldu_i` passes through a 1-entry register to `sldu_o`.
  - All ring ready and valid outputs are 0.
- **Active input and output.**
  - The input facing the receive direction is the only active input. The inactive input holds ready=0.
  - The output in the send direction is the only active output. The inactive output holds valid=0.
- **Injection.** A local flit is sent with `hops = conf_hops - 1`.
- **Ingress head handling.**
  - hops==0: eject to `sldu_o`.
  - Otherwise: decrement hops and forward to the active output.
  - A blocked head stalls its FIFO (head-of-line blocking is intended).
- **Output arbitration.**
  - Arbitration is between a forwarded flit and `sldu_i`, using a 1-bit round-robin pointer.
  - The pointer flips only on a grant while both requesters are valid.
  - Reset value of the pointer: favour forwarding.
- **Ordering.** Per-source FIFO order is preserved end to end.
- **Output register.** Each ring output is a 1-entry register. It accepts a new flit in the same cycle as it drains (full throughput).

## Timing
- **Ingress FIFO.**
  - Accepts when valid && ready; ready_o = !full.
  - Not fall-through: a flit written at edge t is at the head in cycle t+1.
- **Latencies.**
  - Ring in to ring out: flit accepted in cycle t is valid on the output at t+2, minimum.
  - Ring in to `sldu_o`: t+1.
  - `sldu_i` to ring out: t+1.
  - Bypass, `sldu_i` to `sldu_o`: t+1.
- **Throughput.** One flit per cycle per port when downstream ready is held at 1.
- **FIFO full.** With FifoDepth entries held, ready_o=0. If an entry pops in a cycle, ready_o returns to 1 in the next cycle; there is no same-cycle pass-through.
- **Handshakes.** Valid must not depend on ready. Data is held stable while valid && !ready.
- **Reset.**
  - While `rst_i`=1: all ready and valid outputs are 0.
  - After the clock edge: FIFOs are empty, registers are cleared, `busy_o`=0, `conf_err_o`=0, counters are 0.
  - Reset asserted mid-transfer drops all in-flight flits.

## Configuration
- **`ARA_RING_ROUTER_PERF_EN` defined.**
  - The four 32-bit counters are instantiated: forwarded flits, injected flits, ejected flits, and cycles in which an active-output valid is stalled by ready=0.
  - Counters wrap modulo 2^32 and are cleared by reset.
- **Not defined.** The perf outputs are constant 0 and no counter flops exist.

## Structure
- Add to `ara_pkg`:
  - `ring_flit_t` (hops + `elen_t` payload).
  - `ring_conf_t` (dir, bypass, hops).
  - `RingDirLeft` / `RingDirRight` constants.
- Sub-module `ara_ring_fifo`: parametrised depth and type, synchronous active-high reset, with full, empty and usage outputs. It is instantiated once per ring input. The common_cells FIFOs are not used because their reset style does not match.

## Test plan
- **Single hop.** Configure dir=1, hops=1; inject data 0xA5 on `sldu_i`. `ring_right_o` = {0, 0xA5} one cycle later. Then feed {0, 0x5A} on `ring_left_i`: `sldu_o`=0x5A one cycle later.
- **Multi-hop.** Configure hops=3 with a 4-router ring in the bench. A flit injected at cluster 0 ejects only at cluster 3, and intermediate routers show hops 2, 1, 0.
- **Contention.** Forward traffic and local injection are both continuously valid. Grants alternate, the counts after 20 cycles are 10/10, and per-source order is kept.
- **Backpressure.** Hold `ring_right_ready_i`=0 with FifoDepth=2. The ingress fills, ring ready drops to 0 after 2 accepts plus the 1 flit in the output register, and no data is lost on release.
- **Configuration while busy.** Set `conf_valid_i` with one flit buffered. `conf_err_o` pulses and the old direction is kept. After draining, the same configuration is accepted.
- **Hops=0 and performance counters.** With hops=0, behaviour equals bypass (0x11 loops in 1 cycle). With `ARA_RING_ROUTER_PERF_EN` defined, `perf_inj_o` increments by 1 per injected flit.
